cond_flag_unit: RTL and testbench

//  Consumer end of the ALU status outputs. Holds the architectural NZCV flag register and

---
 rtl/cond_pkg.sv | 20 ++
 rtl/cond_eval.sv | 24 ++
 rtl/cond_flag_unit.sv | 72 +++++++
 tb/tb_cond_flag_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: shared NZCV flag, condition-code and FSM state types for the condition unit.
package cond_pkg;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_e;

   typedef enum logic {IDLE, HOLD} state_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: A64 condition-code evaluation over an NZCV flag set.
module cond_eval
   import cond_pkg::*;
(
   input  flags_t flags,
   input  cond_e  cond,
   output logic   cond_true
);

   logic base;

   // Odd codes invert the even base test, except NV which behaves as AL.
   always_comb begin
      base = (cond[3:1] == 3'd0) ? flags.z :
             (cond[3:1] == 3'd1) ? flags.c :
             (cond[3:1] == 3'd2) ? flags.n :
             (cond[3:1] == 3'd3) ? flags.v :
             (cond[3:1] == 3'd4) ? (flags.c & ~flags.z) :
             (cond[3:1] == 3'd5) ? (flags.n == flags.v) :
             (cond[3:1] == 3'd6) ? (~flags.z & (flags.n == flags.v)) : 1'b1;
      cond_true = (cond[0] && cond[3:1] != 3'd7) ? ~base : base;
   end

endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register, ID-stage B.cond resolution and flag-hazard stall.
module cond_flag_unit
   import cond_pkg::*;
#(
   parameter int FWD_EX        = 1,
   parameter int HAZARD_STALLS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ex_valid,
   input  logic       ex_set_flags,
   input  logic       ex_negative,
   input  logic       ex_zero,
   input  logic       ex_carry_out,
   input  logic       ex_overflow,
   input  logic       id_cond_br,
   input  logic [3:0] id_cond,
   output logic [3:0] flags_q,
   output logic       br_taken,
   output logic       stall
);

   flags_t fq, ex_flags, src;
   state_e state;
   logic [2:0] cnt;
   logic hazard, cond_true, wr;

   assign ex_flags = flags_t'({ex_negative, ex_zero, ex_carry_out, ex_overflow});
   assign flags_q  = fq;
   assign wr       = ex_valid & ex_set_flags;

   always_comb begin
      hazard   = id_cond_br & wr;
      src      = (FWD_EX != 0 && hazard) ? ex_flags : fq;
      stall    = (FWD_EX == 0) && !reset && (state == HOLD || hazard);
      br_taken = id_cond_br & cond_true & ~stall & ~reset;
   end

   cond_eval u_eval (
      .flags     (src),
      .cond      (cond_e'(id_cond)),
      .cond_true (cond_true)
   );

   // The EX instruction always retires, so the write ignores stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fq <= '0;
      else if (wr)
         fq <= ex_flags;
   end

   // EX holds a bubble while in HOLD, so only the counter decides when to leave.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (FWD_EX == 0) begin
         if (state == IDLE) begin
            if (hazard && HAZARD_STALLS > 1) begin
               state <= HOLD;
               cnt   <= 3'(HAZARD_STALLS - 1);
            end
         end else begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1)
               state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: scoreboard bench over three configurations (stall x1, forward, stall x3).
module tb_cond_flag_unit;

   typedef struct packed {
      logic ev, sf, n, z, c, v, cb;
      logic [3:0] cond;
   } in_t;

   typedef struct {
      int         k;
      logic       st;
      logic       br;
      logic [3:0] fl;
      string      nm;
   } exp_t;

   logic clk = 0;
   logic reset = 1;
   in_t din [3];
   logic [3:0] fq [3];
   logic st [3];
   logic bt [3];
   exp_t q [$];
   exp_t e;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cond_flag_unit #(.FWD_EX(0), .HAZARD_STALLS(1)) u_d0 (
      .clk(clk), .reset(reset), .ex_valid(din[0].ev), .ex_set_flags(din[0].sf),
      .ex_negative(din[0].n), .ex_zero(din[0].z), .ex_carry_out(din[0].c), .ex_overflow(din[0].v),
      .id_cond_br(din[0].cb), .id_cond(din[0].cond), .flags_q(fq[0]), .br_taken(bt[0]), .stall(st[0]));

   cond_flag_unit #(.FWD_EX(1), .HAZARD_STALLS(1)) u_d1 (
      .clk(clk), .reset(reset), .ex_valid(din[1].ev), .ex_set_flags(din[1].sf),
      .ex_negative(din[1].n), .ex_zero(din[1].z), .ex_carry_out(din[1].c), .ex_overflow(din[1].v),
      .id_cond_br(din[1].cb), .id_cond(din[1].cond), .flags_q(fq[1]), .br_taken(bt[1]), .stall(st[1]));

   cond_flag_unit #(.FWD_EX(0), .HAZARD_STALLS(3)) u_d2 (
      .clk(clk), .reset(reset), .ex_valid(din[2].ev), .ex_set_flags(din[2].sf),
      .ex_negative(din[2].n), .ex_zero(din[2].z), .ex_carry_out(din[2].c), .ex_overflow(din[2].v),
      .id_cond_br(din[2].cb), .id_cond(din[2].cond), .flags_q(fq[2]), .br_taken(bt[2]), .stall(st[2]));

   function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && n == v;
         4'hD: return z || n != v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic in_t mk(input logic ev, input logic sf, input logic [3:0] f,
                              input logic cb, input logic [3:0] cond);
      in_t r;
      r.ev = ev;
      r.sf = sf;
      {r.n, r.z, r.c, r.v} = f;
      r.cb = cb;
      r.cond = cond;
      return r;
   endfunction

   task automatic push(input int k, input logic es, input logic eb, input logic [3:0] ef,
                       input string nm);
      exp_t x;
      x.k = k;
      x.st = es;
      x.br = eb;
      x.fl = ef;
      x.nm = nm;
      q.push_back(x);
   endtask

   task automatic step(input int k, input in_t v, input logic es, input logic eb,
                       input logic [3:0] ef, input string nm);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) din[i] = '0;
      din[k] = v;
      push(k, es, eb, ef, nm);
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         e = q.pop_front();
         checks += 3;
         if (st[e.k] !== e.st) begin
            failures++;
            $display("FAIL %s d%0d stall got=%b want=%b", e.nm, e.k, st[e.k], e.st);
         end
         if (bt[e.k] !== e.br) begin
            failures++;
            $display("FAIL %s d%0d br_taken got=%b want=%b", e.nm, e.k, bt[e.k], e.br);
         end
         if (fq[e.k] !== e.fl) begin
            failures++;
            $display("FAIL %s d%0d flags_q got=%b want=%b", e.nm, e.k, fq[e.k], e.fl);
         end
      end
   end

   initial begin
      logic [3:0] prev;
      for (int i = 0; i < 3; i++) din[i] = mk(1, 1, 4'b0110, 1, 4'h0);
      for (int i = 0; i < 3; i++) push(i, 0, 0, 4'b0000, "reset_state");
      @(posedge clk);
      #1;
      reset = 0;
      for (int i = 0; i < 3; i++) din[i] = '0;

      // Reset while the 3-cycle stall window is in HOLD.
      step(2, mk(1, 1, 4'b0110, 1, 4'h0), 1, 0, 4'b0000, "t1_hazard");
      step(2, mk(0, 0, 4'b0000, 1, 4'h0), 1, 0, 4'b0110, "t1_hold");
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) din[i] = mk(0, 0, 4'b0000, 1, 4'h0);
      reset = 1;
      push(2, 0, 0, 4'b0000, "t1_rst_mid_hold");
      @(posedge clk);
      #1;
      reset = 0;
      step(2, mk(0, 0, 4'b0000, 1, 4'h0), 0, 0, 4'b0000, "t1_eq_after_rst");

      // SUBS 5-5 then B.EQ, stall-once configuration.
      step(0, mk(1, 1, 4'b0110, 1, 4'h0), 1, 0, 4'b0000, "t2_hazard");
      step(0, mk(0, 0, 4'b0000, 1, 4'h0), 0, 1, 4'b0110, "t2_eq_taken");
      step(0, '0, 0, 0, 4'b0110, "t2_idle");

      // Same stimulus with forwarding.
      step(1, mk(1, 1, 4'b0110, 1, 4'h0), 0, 1, 4'b0000, "t3_fwd_taken");
      step(1, '0, 0, 0, 4'b0110, "t3_flags");

      // ADDS 0x7FFF_FFFF_FFFF_FFFF+1 then B.GE with three stall cycles.
      step(2, mk(1, 1, 4'b1001, 1, 4'hA), 1, 0, 4'b0000, "t4_hazard");
      step(2, mk(0, 0, 4'b0000, 1, 4'hA), 1, 0, 4'b1001, "t4_hold1");
      step(2, mk(0, 0, 4'b0000, 1, 4'hA), 1, 0, 4'b1001, "t4_hold2");
      step(2, mk(0, 0, 4'b0000, 1, 4'hA), 0, 1, 4'b1001, "t4_ge_taken");
      step(2, mk(0, 0, 4'b0000, 1, 4'hB), 0, 0, 4'b1001, "t4_lt_not");

      // Flag-setting bubble is neither a write nor a hazard.
      step(0, mk(0, 1, 4'b0000, 1, 4'h1), 0, 0, 4'b0110, "t6_ne_old_d0");
      step(0, '0, 0, 0, 4'b0110, "t6_unchanged_d0");
      step(1, mk(0, 1, 4'b0000, 1, 4'h1), 0, 0, 4'b0110, "t6_ne_old_d1");
      step(1, '0, 0, 0, 4'b0110, "t6_unchanged_d1");

      // No B.cond in ID: no stall even though EX writes flags.
      step(0, mk(1, 1, 4'b0000, 0, 4'h0), 0, 0, 4'b0110, "nobr_d0");
      step(0, '0, 0, 0, 4'b0000, "nobr_write_d0");

      // Full condition table against every registered flag value.
      for (int k = 0; k < 3; k++) begin
         prev = (k == 0) ? 4'b0000 : (k == 1) ? 4'b0110 : 4'b1001;
         for (int f = 0; f < 16; f++) begin
            step(k, mk(1, 1, 4'(f), 0, 4'h0), 0, 0, prev, "t5_load");
            prev = 4'(f);
            for (int c = 0; c < 16; c++)
               step(k, mk(0, 0, 4'b0000, 1, 4'(c)), 0, ref_cond(4'(f), 4'(c)), 4'(f), "t5_sweep");
         end
      end

      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) din[i] = '0;
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
